// File: rtl/i2c_seq_pkg.sv
// -----------------------------------------------------------------------------
// i2c_seq_pkg
// Shared definitions for the I2C byte sequencer. It holds:
//   - register addresses of the I2C master core's 8-bit Wishbone slave
//   - CTR/CR command bytes written by the sequencer
//   - bit positions inside the status register (SR)
//   - the sequencer FSM state type and the response error code type
// -----------------------------------------------------------------------------
package i2c_seq_pkg;

   // Register map (TXR/RXR and CR/SR share an address, split by direction)
   localparam logic [2:0] REG_PRERLO = 3'h0;
   localparam logic [2:0] REG_PRERHI = 3'h1;
   localparam logic [2:0] REG_CTR    = 3'h2;
   localparam logic [2:0] REG_TXR    = 3'h3;
   localparam logic [2:0] REG_RXR    = 3'h3;
   localparam logic [2:0] REG_CR     = 3'h4;
   localparam logic [2:0] REG_SR     = 3'h4;

   // Command bytes
   localparam logic [7:0] CTR_CORE_EN    = 8'h80;  // EN
   localparam logic [7:0] CR_STA_WR      = 8'h90;  // STA | WR
   localparam logic [7:0] CR_WR_STO      = 8'h50;  // WR | STO
   localparam logic [7:0] CR_RD_NACK_STO = 8'h68;  // RD | ACK(=NACK) | STO
   localparam logic [7:0] CR_STO         = 8'h40;  // STO

   // Status register bits
   localparam int SR_RXACK = 7;
   localparam int SR_AL    = 5;
   localparam int SR_TIP   = 1;

   typedef enum logic [3:0] {
      ST_INIT_PRERLO,
      ST_INIT_PRERHI,
      ST_INIT_CTR,
      ST_IDLE,
      ST_ADDR_TX,
      ST_ADDR_CR,
      ST_POLL,
      ST_CHECK,
      ST_DATA_TX,
      ST_DATA_CR,
      ST_RD_CR,
      ST_RD_RX,
      ST_STOP,
      ST_RESP
   } seq_state_e;

   typedef enum logic [2:0] {
      ERR_OK        = 3'd0,
      ERR_ADDR_NACK = 3'd1,
      ERR_DATA_NACK = 3'd2,
      ERR_ARB_LOST  = 3'd3,
      ERR_TIMEOUT   = 3'd4
   } rsp_err_e;

endpackage

// File: rtl/i2c_seq_wb_if.sv
// -----------------------------------------------------------------------------
// i2c_seq_wb_if
// Single-access Wishbone master. A request (req with we/adr/dat) is launched
// onto the bus when no access is in flight; stb/cyc and adr/dat/we are held
// until wb_ack_i, dropped on the following cycle, and done pulses for one
// cycle. A new access is never launched while done is high, so at least one
// idle bus cycle separates consecutive accesses.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   req, we, adr, dat         access request from the sequencer FSM
//   done                      one-cycle pulse after the acknowledged cycle
//   rdata                     read data captured on the ack cycle (reads only)
//   wb_adr_o .. wb_ack_i      Wishbone master signals (cyc mirrors stb)
// -----------------------------------------------------------------------------
module i2c_seq_wb_if (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       req,
   input  logic       we,
   input  logic [2:0] adr,
   input  logic [7:0] dat,
   output logic       done,
   output logic [7:0] rdata,
   output logic [2:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   output logic       wb_we_o,
   output logic       wb_stb_o,
   output logic       wb_cyc_o,
   input  logic       wb_ack_i
);

   assign wb_cyc_o = wb_stb_o;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         done     <= 1'b0;
         rdata    <= 8'h00;
         wb_adr_o <= 3'h0;
         wb_dat_o <= 8'h00;
         wb_we_o  <= 1'b0;
         wb_stb_o <= 1'b0;
      end else begin
         done <= 1'b0;
         if (wb_stb_o) begin
            if (wb_ack_i) begin
               wb_stb_o <= 1'b0;
               wb_we_o  <= 1'b0;
               done     <= 1'b1;
               if (!wb_we_o) rdata <= wb_dat_i;
            end
         end else if (req && !done) begin
            wb_stb_o <= 1'b1;
            wb_we_o  <= we;
            wb_adr_o <= adr;
            wb_dat_o <= dat;
         end
      end
   end

endmodule

// File: rtl/i2c_wb_byte_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_wb_byte_sequencer
// Wishbone master that drives the I2C master core through its register map.
// After reset it programs PRERlo/PRERhi with PRESCALE and enables the core,
// then executes single-byte write/read commands accepted on a valid/ready
// port and returns read data plus an error code as a one-cycle response.
// Optional build macro I2C_SEQ_RETRY_EN: address NACK and arbitration loss are
// retried up to MAX_RETRIES times before the error is reported.
// Ports:
//   wb_clk_i, wb_rst_i                 clock, synchronous active-high reset
//   cmd_valid_i, cmd_ready_o           command handshake
//   cmd_addr_i, cmd_rw_i, cmd_wdata_i  7-bit slave address, 1=read, write byte
//   rsp_valid_o, rsp_rdata_o, rsp_err_o  response strobe, read byte, error code
//   wb_adr_o .. wb_ack_i               Wishbone master to the I2C core
// -----------------------------------------------------------------------------
module i2c_wb_byte_sequencer
   import i2c_seq_pkg::*;
#(
   parameter logic [15:0] PRESCALE     = 16'd99,
   parameter logic [31:0] POLL_TIMEOUT = 32'd1_000_000
`ifdef I2C_SEQ_RETRY_EN
   , parameter int unsigned MAX_RETRIES = 4
`endif
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [6:0] cmd_addr_i,
   input  logic       cmd_rw_i,
   input  logic [7:0] cmd_wdata_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_rdata_o,
   output logic [2:0] rsp_err_o,
   output logic [2:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   output logic       wb_we_o,
   output logic       wb_stb_o,
   output logic       wb_cyc_o,
   input  logic       wb_ack_i
);

   seq_state_e  state;
   rsp_err_e    err_q;
   logic [6:0]  addr_q;
   logic        rw_q;
   logic [7:0]  wdata_q;
   logic        data_phase;   // 0: address byte in flight, 1: data byte
   logic [31:0] poll_cnt;
`ifdef I2C_SEQ_RETRY_EN
   localparam int unsigned RETRY_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
   logic [RETRY_W-1:0] retry_cnt;
`endif

   logic       req, we, done;
   logic [2:0] adr;
   logic [7:0] dat, rdata;

   // Access request per state. The TXR write of the address byte is launched
   // straight from the IDLE handshake so stb rises the cycle after it.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      req = 1'b0;
      we  = 1'b1;
      adr = REG_PRERLO;
      dat = 8'h00;
      case (state)
         ST_INIT_PRERLO: begin req = 1'b1; adr = REG_PRERLO; dat = PRESCALE[7:0];  end
         ST_INIT_PRERHI: begin req = 1'b1; adr = REG_PRERHI; dat = PRESCALE[15:8]; end
         ST_INIT_CTR:    begin req = 1'b1; adr = REG_CTR;    dat = CTR_CORE_EN;    end
         ST_IDLE:        begin
            req = cmd_valid_i && cmd_ready_o;
            adr = REG_TXR;
            dat = {cmd_addr_i, cmd_rw_i};
         end
         ST_ADDR_TX:     begin req = 1'b1; adr = REG_TXR; dat = {addr_q, rw_q};  end
         ST_ADDR_CR:     begin req = 1'b1; adr = REG_CR;  dat = CR_STA_WR;       end
         ST_POLL:        begin req = 1'b1; we = 1'b0; adr = REG_SR;              end
         ST_DATA_TX:     begin req = 1'b1; adr = REG_TXR; dat = wdata_q;         end
         ST_DATA_CR:     begin req = 1'b1; adr = REG_CR;  dat = CR_WR_STO;       end
         ST_RD_CR:       begin req = 1'b1; adr = REG_CR;  dat = CR_RD_NACK_STO;  end
         ST_RD_RX:       begin req = 1'b1; we = 1'b0; adr = REG_RXR;             end
         ST_STOP:        begin req = 1'b1; adr = REG_CR;  dat = CR_STO;          end
         default: ;
      endcase
   end

   i2c_seq_wb_if u_wb_if (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .req      (req),
      .we       (we),
      .adr      (adr),
      .dat      (dat),
      .done     (done),
      .rdata    (rdata),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_we_o  (wb_we_o),
      .wb_stb_o (wb_stb_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_ack_i (wb_ack_i)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= ST_INIT_PRERLO;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= 8'h00;
         rsp_err_o   <= ERR_OK;
         err_q       <= ERR_OK;
         addr_q      <= 7'h00;
         rw_q        <= 1'b0;
         wdata_q     <= 8'h00;
         data_phase  <= 1'b0;
         poll_cnt    <= 32'd0;
`ifdef I2C_SEQ_RETRY_EN
         retry_cnt   <= '0;
`endif
      end else begin
         rsp_valid_o <= 1'b0;
         case (state)
            ST_INIT_PRERLO: if (done) state <= ST_INIT_PRERHI;
            ST_INIT_PRERHI: if (done) state <= ST_INIT_CTR;
            ST_INIT_CTR: if (done) begin
               state       <= ST_IDLE;
               cmd_ready_o <= 1'b1;
            end
            ST_IDLE: if (cmd_valid_i && cmd_ready_o) begin
               addr_q      <= cmd_addr_i;
               rw_q        <= cmd_rw_i;
               wdata_q     <= cmd_wdata_i;
               data_phase  <= 1'b0;
               cmd_ready_o <= 1'b0;
               state       <= ST_ADDR_TX;
`ifdef I2C_SEQ_RETRY_EN
               retry_cnt   <= '0;
`endif
            end
            ST_ADDR_TX: if (done) state <= ST_ADDR_CR;
            ST_DATA_TX: if (done) state <= ST_DATA_CR;
            ST_ADDR_CR, ST_DATA_CR, ST_RD_CR: if (done) begin
               poll_cnt <= 32'd0;
               state    <= ST_POLL;
            end
            ST_POLL: begin
               poll_cnt <= poll_cnt + 32'd1;
               // Timeout is only taken between reads so no access is orphaned.
               if (done) begin
                  if (!rdata[SR_TIP]) begin
                     state <= ST_CHECK;
                  end else if (poll_cnt >= POLL_TIMEOUT) begin
                     err_q <= ERR_TIMEOUT;
                     state <= ST_STOP;
                  end
               end
            end
            ST_CHECK: begin
               if (rdata[SR_AL]) begin
                  // Core has already released the bus: no STOP write.
`ifdef I2C_SEQ_RETRY_EN
                  if (retry_cnt < RETRY_W'(MAX_RETRIES)) begin
                     retry_cnt  <= retry_cnt + 1'b1;
                     data_phase <= 1'b0;
                     state      <= ST_ADDR_TX;
                  end else begin
                     rsp_valid_o <= 1'b1;
                     rsp_rdata_o <= 8'h00;
                     rsp_err_o   <= ERR_ARB_LOST;
                     state       <= ST_RESP;
                  end
`else
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= 8'h00;
                  rsp_err_o   <= ERR_ARB_LOST;
                  state       <= ST_RESP;
`endif
               end else if (!data_phase && rdata[SR_RXACK]) begin
                  err_q <= ERR_ADDR_NACK;
                  state <= ST_STOP;
               end else if (data_phase && !rw_q && rdata[SR_RXACK]) begin
                  // DATA_CR carried STO, so the bus is already stopped.
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= 8'h00;
                  rsp_err_o   <= ERR_DATA_NACK;
                  state       <= ST_RESP;
               end else if (!data_phase) begin
                  data_phase <= 1'b1;
                  state      <= rw_q ? ST_RD_CR : ST_DATA_TX;
               end else if (rw_q) begin
                  state <= ST_RD_RX;
               end else begin
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= 8'h00;
                  rsp_err_o   <= ERR_OK;
                  state       <= ST_RESP;
               end
            end
            ST_RD_RX: if (done) begin
               rsp_valid_o <= 1'b1;
               rsp_rdata_o <= rdata;
               rsp_err_o   <= ERR_OK;
               state       <= ST_RESP;
            end
            ST_STOP: if (done) begin
`ifdef I2C_SEQ_RETRY_EN
               if (err_q == ERR_ADDR_NACK && retry_cnt < RETRY_W'(MAX_RETRIES)) begin
                  retry_cnt  <= retry_cnt + 1'b1;
                  data_phase <= 1'b0;
                  state      <= ST_ADDR_TX;
               end else begin
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= 8'h00;
                  rsp_err_o   <= err_q;
                  state       <= ST_RESP;
               end
`else
               rsp_valid_o <= 1'b1;
               rsp_rdata_o <= 8'h00;
               rsp_err_o   <= err_q;
               state       <= ST_RESP;
`endif
            end
            ST_RESP: begin
               cmd_ready_o <= 1'b1;
               state       <= ST_IDLE;
            end
            default: state <= ST_INIT_PRERLO;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_wb_byte_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_wb_byte_sequencer
// Directed bench for i2c_wb_byte_sequencer. A small Wishbone slave model acks
// every access one cycle after stb rises, logs writes and RXR reads, and
// returns SR values configured per test (TIP cycles, address/data phase SR).
// Expected bus traffic and responses are written out by hand per command.
// Honours I2C_SEQ_RETRY_EN for the number of expected address attempts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_wb_byte_sequencer;

`ifdef I2C_SEQ_RETRY_EN
   localparam int ATTEMPTS = 5;
`else
   localparam int ATTEMPTS = 1;
`endif

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic [6:0] cmd_addr_i;
   logic       cmd_rw_i;
   logic [7:0] cmd_wdata_i;
   logic       rsp_valid_o;
   logic [7:0] rsp_rdata_o;
   logic [2:0] rsp_err_o;
   logic [2:0] wb_adr_o;
   logic [7:0] wb_dat_o;
   logic [7:0] wb_dat_i;
   logic       wb_we_o;
   logic       wb_stb_o;
   logic       wb_cyc_o;
   logic       wb_ack_i;

   always #5 wb_clk_i = ~wb_clk_i;

   i2c_wb_byte_sequencer #(
      .PRESCALE     (16'd99),
      .POLL_TIMEOUT (32'd20)
   ) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_rw_i    (cmd_rw_i),
      .cmd_wdata_i (cmd_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .wb_adr_o    (wb_adr_o),
      .wb_dat_o    (wb_dat_o),
      .wb_dat_i    (wb_dat_i),
      .wb_we_o     (wb_we_o),
      .wb_stb_o    (wb_stb_o),
      .wb_cyc_o    (wb_cyc_o),
      .wb_ack_i    (wb_ack_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Slave model state: {we, adr, dat} per logged access
   logic [11:0] log_q[$];
   logic [11:0] exp_q[$];
   int          sr_reads  = 0;
   int          cur_polls = 0;
   int          tip_polls = 0;
   bit          tip_stuck = 0;
   logic [7:0]  sr_addr   = 8'h00;
   logic [7:0]  sr_data   = 8'h00;
   logic [7:0]  rxr_val   = 8'h00;
   logic [7:0]  last_cr   = 8'h00;
   int          rsp_count = 0;

   always @(negedge wb_clk_i) begin
      if (wb_ack_i) begin
         wb_ack_i = 1'b0;
      end else if (wb_stb_o) begin
         wb_ack_i = 1'b1;
         if (wb_we_o) begin
            log_q.push_back({1'b1, wb_adr_o, wb_dat_o});
            if (wb_adr_o == 3'h4) begin
               last_cr   = wb_dat_o;
               cur_polls = 0;
            end
         end else if (wb_adr_o == 3'h4) begin
            sr_reads++;
            if (tip_stuck || cur_polls < tip_polls) wb_dat_i = 8'h02;
            else wb_dat_i = (last_cr == 8'h90) ? sr_addr : sr_data;
            cur_polls++;
         end else begin
            wb_dat_i = rxr_val;
            log_q.push_back({1'b0, wb_adr_o, rxr_val});
         end
      end
   end

   always @(negedge wb_clk_i) if (rsp_valid_o) rsp_count++;

   task automatic expw(input logic [2:0] a, input logic [7:0] d);
      exp_q.push_back({1'b1, a, d});
   endtask

   task automatic expr(input logic [2:0] a, input logic [7:0] d);
      exp_q.push_back({1'b0, a, d});
   endtask

   task automatic compare_log(input string tag);
      check({tag, "_len"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         check($sformatf("%s_acc%0d", tag, i), log_q[i], exp_q[i]);
      log_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_ready(input string tag);
      for (int n = 0; n < 200 && !cmd_ready_o; n++) @(negedge wb_clk_i);
      check(tag, cmd_ready_o, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, cmd_ready_o, 0);
      check({tag, "_rspv"},  rsp_valid_o, 0);
      check({tag, "_rdata"}, rsp_rdata_o, 0);
      check({tag, "_err"},   rsp_err_o, 0);
      check({tag, "_bus"},   {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 0);
   endtask

   // Issues one command (called at a negedge), returns the response.
   task automatic run_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                          output logic [7:0] rd, output logic [2:0] er);
      cmd_addr_i  = a;
      cmd_rw_i    = rw;
      cmd_wdata_i = wd;
      cmd_valid_i = 1'b1;
      wait_ready("cmd_ready");
      @(posedge wb_clk_i);
      #1 cmd_valid_i = 1'b0;
      @(negedge wb_clk_i);
      check("stb_latency", wb_stb_o, 1);
      check("ready_drop", cmd_ready_o, 0);
      for (int n = 0; n < 3000 && !rsp_valid_o; n++) @(negedge wb_clk_i);
      check("rsp_wait", rsp_valid_o, 1);
      rd = rsp_rdata_o;
      er = rsp_err_o;
      @(negedge wb_clk_i);
      check("rsp_pulse", rsp_valid_o, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      logic [2:0] er;
      int         snap;
      wb_rst_i    = 1'b1;
      wb_ack_i    = 1'b0;
      wb_dat_i    = 8'h00;
      cmd_valid_i = 1'b0;
      cmd_addr_i  = 7'h00;
      cmd_rw_i    = 1'b0;
      cmd_wdata_i = 8'h00;
      repeat (3) @(negedge wb_clk_i);
      check_reset_outputs("rst");
      log_q.delete();
      wb_rst_i = 1'b0;

      // Init: prescaler 99 = 0x0063, then core enable
      wait_ready("init_ready");
      expw(3'h0, 8'h63); expw(3'h1, 8'h00); expw(3'h2, 8'h80);
      compare_log("init");

      // Write 0x50 <- 0xA5, ACKed, two TIP polls per byte
      tip_polls = 2; sr_addr = 8'h00; sr_data = 8'h00; sr_reads = 0;
      run_cmd(7'h50, 1'b0, 8'hA5, rd, er);
      expw(3'h3, 8'hA0); expw(3'h4, 8'h90); expw(3'h3, 8'hA5); expw(3'h4, 8'h50);
      compare_log("wr");
      check("wr_err", er, 0);
      check("wr_rdata", rd, 0);
      check("wr_polls", sr_reads, 6);

      // Read 0x50 -> 0x3C
      tip_polls = 1; rxr_val = 8'h3C;
      run_cmd(7'h50, 1'b1, 8'h00, rd, er);
      expw(3'h3, 8'hA1); expw(3'h4, 8'h90); expw(3'h4, 8'h68); expr(3'h3, 8'h3C);
      compare_log("rd");
      check("rd_err", er, 0);
      check("rd_rdata", rd, 8'h3C);

      // Data NACK on write: error 2, rdata back to 0
      tip_polls = 0; sr_data = 8'h80;
      run_cmd(7'h50, 1'b0, 8'h5A, rd, er);
      expw(3'h3, 8'hA0); expw(3'h4, 8'h90); expw(3'h3, 8'h5A); expw(3'h4, 8'h50);
      compare_log("dnack");
      check("dnack_err", er, 2);
      check("dnack_rdata", rd, 0);

      // Address NACK: STOP written, error 1 (retried when enabled)
      sr_addr = 8'h80; sr_data = 8'h00;
      run_cmd(7'h21, 1'b0, 8'h11, rd, er);
      for (int i = 0; i < ATTEMPTS; i++) begin
         expw(3'h3, 8'h42); expw(3'h4, 8'h90); expw(3'h4, 8'h40);
      end
      compare_log("anack");
      check("anack_err", er, 1);

      // Arbitration lost on first poll: no STOP, error 3
      sr_addr = 8'h20;
      run_cmd(7'h50, 1'b1, 8'h00, rd, er);
      for (int i = 0; i < ATTEMPTS; i++) begin
         expw(3'h3, 8'hA1); expw(3'h4, 8'h90);
      end
      compare_log("al");
      check("al_err", er, 3);
      check("al_rdata", rd, 0);

      // TIP stuck: timeout, STOP written, error 4, never retried
      sr_addr = 8'h00; tip_stuck = 1;
      run_cmd(7'h50, 1'b0, 8'hC3, rd, er);
      expw(3'h3, 8'hA0); expw(3'h4, 8'h90); expw(3'h4, 8'h40);
      compare_log("tmo");
      check("tmo_err", er, 4);

      // Reset while polling: immediate abort, init re-runs, no response
      sr_reads = 0;
      cmd_addr_i = 7'h50; cmd_rw_i = 1'b0; cmd_wdata_i = 8'h77; cmd_valid_i = 1'b1;
      wait_ready("mid_ready");
      @(posedge wb_clk_i);
      #1 cmd_valid_i = 1'b0;
      for (int n = 0; n < 100 && sr_reads == 0; n++) @(negedge wb_clk_i);
      check("mid_in_poll", (sr_reads > 0), 1);
      snap = rsp_count;
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      check_reset_outputs("mid_rst");
      tip_stuck = 0;
      log_q.delete();
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      wait_ready("reinit_ready");
      expw(3'h0, 8'h63); expw(3'h1, 8'h00); expw(3'h2, 8'h80);
      compare_log("reinit");
      check("mid_no_rsp", rsp_count, snap);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
